// File: rtl/run_step_ctl_if.sv
// rtl/run_step_ctl_if.sv - console request and processor clock-control signal bundle
interface run_step_ctl_if #(
  parameter int STEP_W = 8
);
  logic              run_req;
  logic              step_req;
  logic              halt_req;
  logic [STEP_W-1:0] step_cnt;
  logic              err_halt;
  logic              err_stop_en;
  logic              clk_en;
  logic              j_run;
  logic              k_run;
  logic              ssdone;
  logic              halted;
  logic [STEP_W-1:0] steps_left;

  modport master (
    output run_req, step_req, halt_req, step_cnt, err_halt, err_stop_en,
    input  clk_en, j_run, k_run, ssdone, halted, steps_left
  );

  modport slave (
    input  run_req, step_req, halt_req, step_cnt, err_halt, err_stop_en,
    output clk_en, j_run, k_run, ssdone, halted, steps_left
  );
endinterface

// File: rtl/run_step_ctl.sv
// rtl/run_step_ctl.sv - run/halt/single-step controller driving processor clock enable and RUN JK flop
module run_step_ctl #(
  parameter int STEP_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  run_step_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              run_prev, step_prev, halt_prev;
  logic              run_rise, step_rise, halt_rise, errh, stop;
  logic              clk_en_d, j_run_d, k_run_d, ssdone_d, halted_d;

  assign run_rise  = bus.run_req  & ~run_prev;
  assign step_rise = bus.step_req & ~step_prev;
  assign halt_rise = bus.halt_req & ~halt_prev;
  assign errh      = bus.err_halt & bus.err_stop_en;
  assign stop      = errh | halt_rise;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HALT: begin
        if (stop) begin
          state_d = ST_HALT;
        end else if (step_rise) begin
          state_d = ST_STEP;
          cnt_d   = (bus.step_cnt == '0) ? STEP_W'(1) : bus.step_cnt;
        end else if (run_rise) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) state_d = ST_HALT;
      end
      ST_STEP: begin
        if (stop) begin
          state_d = ST_HALT;
          cnt_d   = '0;
        end else if (cnt_q <= STEP_W'(1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - STEP_W'(1);
        end
      end
      default: begin
        state_d = ST_HALT;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so nothing from the inputs reaches a pin combinationally
    clk_en_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    j_run_d  = clk_en_d && (state_q == ST_HALT);
    k_run_d  = (state_d == ST_HALT) && (state_q != ST_HALT);
    ssdone_d = (state_d == ST_DONE);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_HALT;
      cnt_q          <= '0;
      run_prev       <= 1'b1;
      step_prev      <= 1'b1;
      halt_prev      <= 1'b1;
      bus.clk_en     <= 1'b0;
      bus.j_run      <= 1'b0;
      bus.k_run      <= 1'b0;
      bus.ssdone     <= 1'b0;
      bus.halted     <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      run_prev       <= bus.run_req;
      step_prev      <= bus.step_req;
      halt_prev      <= bus.halt_req;
      bus.clk_en     <= clk_en_d;
      bus.j_run      <= j_run_d;
      bus.k_run      <= k_run_d;
      bus.ssdone     <= ssdone_d;
      bus.halted     <= halted_d;
    end
  end

  assign bus.steps_left = cnt_q;

endmodule

// File: tb/tb_run_step_ctl.sv
// tb/tb_run_step_ctl.sv - scoreboard bench for run_step_ctl
module tb_run_step_ctl;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned ncyc = 0;
  int total = 0;
  int passed = 0;

  typedef struct {
    int unsigned at;
    bit          ce, j, k, sd, hl;
    logic [7:0]  sl;
    string       nm;
  } exp_t;

  exp_t q[$];

  run_step_ctl_if #(.STEP_W(8)) bus ();

  run_step_ctl #(.STEP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= ncyc) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".clk_en"},     32'(bus.clk_en),     32'(e.ce));
      chk({e.nm, ".j_run"},      32'(bus.j_run),      32'(e.j));
      chk({e.nm, ".k_run"},      32'(bus.k_run),      32'(e.k));
      chk({e.nm, ".ssdone"},     32'(bus.ssdone),     32'(e.sd));
      chk({e.nm, ".halted"},     32'(bus.halted),     32'(e.hl));
      chk({e.nm, ".steps_left"}, 32'(bus.steps_left), 32'(e.sl));
    end
  end

  // Expected outputs after the coming rising edge; returns at the following falling edge
  task automatic tick(input bit ce, j, k, sd, hl, input logic [7:0] sl, input string nm);
    exp_t e;
    e.at = ncyc + 1;
    e.ce = ce; e.j = j; e.k = k; e.sd = sd; e.hl = hl; e.sl = sl; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input string nm);
    tick(0, 0, 0, 0, 1, 8'd0, nm);
  endtask

  task automatic kick(input string nm);
    tick(0, 0, 1, 0, 1, 8'd0, nm);
  endtask

  task automatic finish_step(input string nm);
    tick(0, 0, 0, 1, 0, 8'd0, {nm, "_done"});
    kick({nm, "_k"});
    idle({nm, "_idle"});
  endtask

  initial begin
    bus.run_req = 1'b1;
    bus.step_req = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_cnt = 8'd0;
    bus.err_halt = 1'b0;
    bus.err_stop_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.clk_en", 32'(bus.clk_en), 0);
    chk("rst.j_run", 32'(bus.j_run), 0);
    chk("rst.k_run", 32'(bus.k_run), 0);
    chk("rst.ssdone", 32'(bus.ssdone), 0);
    chk("rst.halted", 32'(bus.halted), 1);
    chk("rst.steps_left", 32'(bus.steps_left), 0);
    rst_n = 1'b1;

    idle("rst_hold0");
    idle("rst_hold1");
    bus.run_req = 1'b0;
    idle("run_low");
    bus.run_req = 1'b1;
    tick(1, 1, 0, 0, 0, 8'd0, "run_enter");
    for (int i = 0; i < 20; i++) begin
      if (i == 5) bus.step_req = 1'b1;
      if (i == 6) bus.step_req = 1'b0;
      if (i == 8) bus.run_req = 1'b0;
      if (i == 9) bus.run_req = 1'b1;
      tick(1, 0, 0, 0, 0, 8'd0, "run");
    end
    bus.halt_req = 1'b1;
    kick("run_halt");
    idle("halt_hold");
    bus.halt_req = 1'b0;
    bus.run_req = 1'b0;
    idle("halt_idle");

    bus.step_cnt = 8'd5;
    bus.step_req = 1'b1;
    tick(1, 1, 0, 0, 0, 8'd5, "s5_enter");
    bus.step_req = 1'b0;
    for (int v = 4; v >= 1; v--) tick(1, 0, 0, 0, 0, 8'(v), "s5_step");
    finish_step("s5");

    bus.step_cnt = 8'd0;
    bus.step_req = 1'b1;
    tick(1, 1, 0, 0, 0, 8'd1, "s0_enter");
    bus.step_req = 1'b0;
    finish_step("s0");

    bus.step_cnt = 8'd255;
    bus.step_req = 1'b1;
    tick(1, 1, 0, 0, 0, 8'd255, "s255_enter");
    bus.step_req = 1'b0;
    for (int v = 254; v >= 1; v--) tick(1, 0, 0, 0, 0, 8'(v), "s255_step");
    finish_step("s255");

    bus.err_stop_en = 1'b1;
    bus.step_cnt = 8'd10;
    bus.step_req = 1'b1;
    tick(1, 1, 0, 0, 0, 8'd10, "err_enter");
    bus.step_req = 1'b0;
    tick(1, 0, 0, 0, 0, 8'd9, "err_s2");
    tick(1, 0, 0, 0, 0, 8'd8, "err_s3");
    tick(1, 0, 0, 0, 0, 8'd7, "err_s4");
    bus.err_halt = 1'b1;
    kick("err_abort");
    idle("err_hold");
    bus.step_req = 1'b1;
    idle("err_blocks_step");
    bus.err_halt = 1'b0;
    bus.step_req = 1'b0;
    idle("err_clear");

    bus.err_stop_en = 1'b0;
    bus.err_halt = 1'b1;
    bus.step_req = 1'b1;
    tick(1, 1, 0, 0, 0, 8'd10, "noerr_enter");
    bus.step_req = 1'b0;
    for (int v = 9; v >= 1; v--) tick(1, 0, 0, 0, 0, 8'(v), "noerr_step");
    finish_step("noerr");
    bus.err_halt = 1'b0;
    bus.err_stop_en = 1'b1;

    bus.halt_req = 1'b1;
    bus.run_req = 1'b1;
    idle("sim_halt_run");
    bus.halt_req = 1'b0;
    bus.run_req = 1'b0;
    idle("sim_clear");
    bus.step_cnt = 8'd2;
    bus.step_req = 1'b1;
    bus.run_req = 1'b1;
    tick(1, 1, 0, 0, 0, 8'd2, "sim_step_run");
    bus.step_req = 1'b0;
    bus.run_req = 1'b0;
    tick(1, 0, 0, 0, 0, 8'd1, "sim_step2");
    finish_step("sim");

    bus.run_req = 1'b1;
    tick(1, 1, 0, 0, 0, 8'd0, "rerr_enter");
    bus.run_req = 1'b0;
    tick(1, 0, 0, 0, 0, 8'd0, "rerr_run");
    bus.err_halt = 1'b1;
    kick("rerr_halt");
    bus.err_halt = 1'b0;
    idle("rerr_idle");

    bus.step_cnt = 8'd8;
    bus.step_req = 1'b1;
    tick(1, 1, 0, 0, 0, 8'd8, "ars_enter");
    bus.step_req = 1'b0;
    tick(1, 0, 0, 0, 0, 8'd7, "ars_s2");
    tick(1, 0, 0, 0, 0, 8'd6, "ars_s3");
    #2;
    rst_n = 1'b0;
    #1;
    chk("ars.clk_en", 32'(bus.clk_en), 0);
    chk("ars.steps_left", 32'(bus.steps_left), 0);
    chk("ars.k_run", 32'(bus.k_run), 0);
    chk("ars.halted", 32'(bus.halted), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle("ars_post0");
    idle("ars_post1");
    idle("ars_post2");

    @(negedge clk);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
